// File: rtl/sampler_voice_scheduler.sv
// sampler_voice_scheduler
// Four trigger-driven playback voices sharing one single-port sample RAM
// read port. Each audio frame updates trigger/playback state, then reads the
// RAM once per active voice in voice order and publishes the four voice
// samples together with a saturated mix.
module sampler_voice_scheduler #(
    parameter int W          = 16,
    parameter int ADDR_W     = 12,
    parameter int N_SAMPLES  = 12'h690,
    parameter int FP_OFFSET  = 2,
    parameter int TRIG_HI_MV = 1000,
    parameter int TRIG_LO_MV = 500,
    parameter int RATE_DIV   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              strobe,
    input  logic [W-1:0]      sample_in0,
    input  logic [W-1:0]      sample_in1,
    input  logic [W-1:0]      sample_in2,
    input  logic [W-1:0]      sample_in3,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [W-1:0]      mem_data,
    output logic [W-1:0]      sample_out0,
    output logic [W-1:0]      sample_out1,
    output logic [W-1:0]      sample_out2,
    output logic [W-1:0]      sample_out3,
    output logic [W-1:0]      mix_out,
    output logic [3:0]        active,
    output logic              busy,
    output logic              overrun
);

    // A divider of one still needs a one-bit counter that simply stays at 0.
    localparam int DIV_W = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(RATE_DIV - 1);
    localparam logic [ADDR_W-1:0] POS_LAST = ADDR_W'(N_SAMPLES - 1);

    // Thresholds are given in millivolts; the input counts are mV scaled up.
    localparam logic signed [W-1:0] TRIG_HI = W'(TRIG_HI_MV <<< FP_OFFSET);
    localparam logic signed [W-1:0] TRIG_LO = W'(TRIG_LO_MV <<< FP_OFFSET);

    localparam logic signed [W+1:0] SAT_MAX = (W+2)'((2 ** (W - 1)) - 1);
    localparam logic signed [W+1:0] SAT_MIN = (W+2)'(-(2 ** (W - 1)));

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        MIX   = 2'd3
    } state_t;

    state_t state_q, state_d;
    logic [1:0] v_q, v_d;
    logic [1:0] v_inc, v_dec;

    logic [3:0]                  armed_q, armed_d;
    logic [3:0]                  active_q, active_d;
    logic [3:0][ADDR_W-1:0]      pos_q, pos_d;
    logic [3:0][DIV_W-1:0]       div_q, div_d;
    logic [3:0][W-1:0]           cap_q, cap_d;
    logic [3:0][W-1:0]           out_q, out_d;
    logic [W-1:0]                mix_q, mix_d;
    logic                        mem_rd_q, mem_rd_d;
    logic [ADDR_W-1:0]           mem_addr_q, mem_addr_d;
    logic                        rd_prev_q, rd_prev_d;
    logic                        overrun_q, overrun_d;

    logic [3:0][W-1:0]           sample_in_w;
    logic [3:0]                  fire;
    logic [3:0]                  rearm;
    logic                        frame_start;
    logic signed [W+1:0]         sum_w;

    assign sample_in_w[0] = sample_in0;
    assign sample_in_w[1] = sample_in1;
    assign sample_in_w[2] = sample_in2;
    assign sample_in_w[3] = sample_in3;

    assign frame_start = strobe && (state_q == IDLE);
    assign v_inc       = v_q + 2'd1;
    assign v_dec       = v_q - 2'd1;

    // Schmitt trigger decisions per voice from the current input levels.
    always_comb begin
        fire  = '0;
        rearm = '0;
        for (int v = 0; v < 4; v++) begin
            fire[v]  = armed_q[v] && ($signed(sample_in_w[v]) >= TRIG_HI);
            rearm[v] = ($signed(sample_in_w[v]) < TRIG_LO);
        end
    end

    // Per-frame voice update: fire/restart, rate division and end-of-sample.
    always_comb begin
        armed_d  = armed_q;
        active_d = active_q;
        pos_d    = pos_q;
        div_d    = div_q;
        if (frame_start) begin
            for (int v = 0; v < 4; v++) begin
                if (fire[v]) begin
                    armed_d[v]  = 1'b0;
                    active_d[v] = 1'b1;
                    pos_d[v]    = '0;
                    div_d[v]    = '0;
                end else begin
                    if (rearm[v]) begin
                        armed_d[v] = 1'b1;
                    end
                    if (active_q[v]) begin
                        if (div_q[v] == DIV_LAST) begin
                            div_d[v] = '0;
                            if (pos_q[v] == POS_LAST) begin
                                active_d[v] = 1'b0;
                                pos_d[v]    = '0;
                            end else begin
                                pos_d[v] = pos_q[v] + 1'b1;
                            end
                        end else begin
                            div_d[v] = div_q[v] + 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Sign-extended sum of the four captured voices, wide enough not to wrap.
    always_comb begin
        sum_w = '0;
        for (int v = 0; v < 4; v++) begin
            sum_w = sum_w + $signed({{2{cap_q[v][W-1]}}, cap_q[v]});
        end
    end

    // Frame sequencer: issues one read per voice, captures a cycle later,
    // then mixes and publishes every output in the same cycle.
    always_comb begin
        state_d    = state_q;
        v_d        = v_q;
        mem_rd_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        rd_prev_d  = mem_rd_q;
        cap_d      = cap_q;
        out_d      = out_q;
        mix_d      = mix_q;
        overrun_d  = overrun_q;

        case (state_q)
            IDLE: begin
                if (strobe) begin
                    state_d  = ISSUE;
                    v_d      = 2'd0;
                    mem_rd_d = active_d[0];
                    if (active_d[0]) begin
                        mem_addr_d = pos_d[0];
                    end
                end
            end
            ISSUE: begin
                if (v_q != 2'd0) begin
                    cap_d[v_dec] = rd_prev_q ? mem_data : '0;
                end
                if (v_q == 2'd3) begin
                    state_d = DRAIN;
                end else begin
                    v_d      = v_inc;
                    mem_rd_d = active_q[v_inc];
                    if (active_q[v_inc]) begin
                        mem_addr_d = pos_q[v_inc];
                    end
                end
            end
            DRAIN: begin
                cap_d[3] = rd_prev_q ? mem_data : '0;
                state_d  = MIX;
            end
            MIX: begin
                out_d = cap_q;
                if (sum_w > SAT_MAX) begin
                    mix_d = SAT_MAX[W-1:0];
                end else if (sum_w < SAT_MIN) begin
                    mix_d = SAT_MIN[W-1:0];
                end else begin
                    mix_d = sum_w[W-1:0];
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (strobe && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end
    end

    // State registers; reset abandons any frame in flight and re-arms voices.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            v_q        <= 2'd0;
            armed_q    <= '1;
            active_q   <= '0;
            pos_q      <= '0;
            div_q      <= '0;
            cap_q      <= '0;
            out_q      <= '0;
            mix_q      <= '0;
            mem_rd_q   <= 1'b0;
            mem_addr_q <= '0;
            rd_prev_q  <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            v_q        <= v_d;
            armed_q    <= armed_d;
            active_q   <= active_d;
            pos_q      <= pos_d;
            div_q      <= div_d;
            cap_q      <= cap_d;
            out_q      <= out_d;
            mix_q      <= mix_d;
            mem_rd_q   <= mem_rd_d;
            mem_addr_q <= mem_addr_d;
            rd_prev_q  <= rd_prev_d;
            overrun_q  <= overrun_d;
        end
    end

    assign mem_rd      = mem_rd_q;
    assign mem_addr    = mem_addr_q;
    assign sample_out0 = out_q[0];
    assign sample_out1 = out_q[1];
    assign sample_out2 = out_q[2];
    assign sample_out3 = out_q[3];
    assign mix_out     = mix_q;
    assign active      = active_q;
    assign busy        = (state_q != IDLE);
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_sampler_voice_scheduler.sv
// Directed testbench for sampler_voice_scheduler. Two instances share the
// clock, reset, strobe and trigger inputs: dut_a uses the default length with
// RATE_DIV=2, dut_b uses a 4-word sample with RATE_DIV=1.
module tb_sampler_voice_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        strobe;
    logic [15:0] sample_in0, sample_in1, sample_in2, sample_in3;

    logic [11:0] mem_addr_a, mem_addr_b;
    logic        mem_rd_a, mem_rd_b;
    logic [15:0] mem_data_a = '0;
    logic [15:0] mem_data_b = '0;
    logic [15:0] out0_a, out1_a, out2_a, out3_a, mix_a;
    logic [15:0] out0_b, out1_b, out2_b, out3_b, mix_b;
    logic [3:0]  active_a, active_b;
    logic        busy_a, busy_b, overrun_a, overrun_b;

    int          compared   = 0;
    int          mismatched = 0;

    // RAM model selection for dut_a: 0 = address plus one, 1 = constant word.
    int          mem_mode   = 0;
    logic [15:0] const_data = '0;

    logic        rd_log   [1:6];
    logic [11:0] addr_log [1:6];
    logic        busy_log [1:6];
    logic [3:0]  act_log1;
    logic [15:0] out0_log6;

    // Voice 0 scenario: trigger, playback, end of sample, hysteresis, restart.
    int in0_tab  [14] = '{0, 0, 4000, 4000, 4000, 4000, 4000, 4000, 3000, 4000, 4000, 1000, 4000, 4000};
    int out_a_tab[14] = '{0, 0, 1, 1, 2, 2, 3, 3, 4, 4, 5, 5, 1, 1};
    int adr_a_tab[14] = '{0, 0, 0, 0, 1, 1, 2, 2, 3, 3, 4, 4, 0, 0};
    int act_a_tab[14] = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
    int out_b_tab[14] = '{0, 0, 'h100, 'h101, 'h102, 'h103, 0, 0, 0, 0, 0, 0, 'h100, 'h101};
    int act_b_tab[14] = '{0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1};

    sampler_voice_scheduler dut_a (
        .clk(clk), .rst_n(rst_n), .strobe(strobe),
        .sample_in0(sample_in0), .sample_in1(sample_in1),
        .sample_in2(sample_in2), .sample_in3(sample_in3),
        .mem_addr(mem_addr_a), .mem_rd(mem_rd_a), .mem_data(mem_data_a),
        .sample_out0(out0_a), .sample_out1(out1_a),
        .sample_out2(out2_a), .sample_out3(out3_a),
        .mix_out(mix_a), .active(active_a), .busy(busy_a), .overrun(overrun_a)
    );

    sampler_voice_scheduler #(.N_SAMPLES(4), .RATE_DIV(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .strobe(strobe),
        .sample_in0(sample_in0), .sample_in1(sample_in1),
        .sample_in2(sample_in2), .sample_in3(sample_in3),
        .mem_addr(mem_addr_b), .mem_rd(mem_rd_b), .mem_data(mem_data_b),
        .sample_out0(out0_b), .sample_out1(out1_b),
        .sample_out2(out2_b), .sample_out3(out3_b),
        .mix_out(mix_b), .active(active_b), .busy(busy_b), .overrun(overrun_b)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    // RAM for dut_a: registered read, data valid one clock after mem_rd.
    always @(posedge clk) begin
        if (mem_rd_a) begin
            if (mem_mode == 0) mem_data_a <= 16'(mem_addr_a) + 16'd1;
            else               mem_data_a <= const_data;
        end
    end

    // RAM for dut_b: word a holds 0x100 + a.
    always @(posedge clk) begin
        if (mem_rd_b) mem_data_b <= 16'h0100 + 16'(mem_addr_b);
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // One full frame starting at a falling edge (cycle 0): logs read port
    // and busy for cycles 1..6, returns at the falling edge of cycle 7.
    task automatic applyStimulus(input logic [15:0] i0, input logic [15:0] i1,
                                 input logic [15:0] i2, input logic [15:0] i3);
        sample_in0 = i0;
        sample_in1 = i1;
        sample_in2 = i2;
        sample_in3 = i3;
        strobe     = 1'b1;
        @(negedge clk);
        strobe     = 1'b0;
        act_log1   = active_a;
        for (int c = 1; c <= 6; c++) begin
            rd_log[c]   = mem_rd_a;
            addr_log[c] = mem_addr_a;
            busy_log[c] = busy_a;
            if (c == 6) out0_log6 = out0_a;
            if (c < 6) @(negedge clk);
        end
        @(negedge clk);
    endtask

    initial begin
        strobe     = 1'b0;
        sample_in0 = '0;
        sample_in1 = '0;
        sample_in2 = '0;
        sample_in3 = '0;
        rst_n      = 1'b1;
        #2 rst_n   = 1'b0;
        @(negedge clk);
        checkOutput("reset busy",    32'(busy_a),    32'd0);
        checkOutput("reset active",  32'(active_a),  32'd0);
        checkOutput("reset mem_rd",  32'(mem_rd_a),  32'd0);
        checkOutput("reset mix",     32'(mix_a),     32'd0);
        checkOutput("reset overrun", 32'(overrun_a), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Voice 0 table: trigger, playback, end of sample, hysteresis, restart.
        for (int f = 0; f < 14; f++) begin
            applyStimulus(16'(in0_tab[f]), 16'd0, 16'd0, 16'd0);
            checkOutput($sformatf("f%0d out0_a", f), 32'(out0_a), 32'(out_a_tab[f]));
            checkOutput($sformatf("f%0d out0_a@c6", f), 32'(out0_log6), (f == 0) ? 32'd0 : 32'(out_a_tab[f-1]));
            checkOutput($sformatf("f%0d rd c1", f), 32'(rd_log[1]), 32'(act_a_tab[f]));
            checkOutput($sformatf("f%0d rd c2", f), 32'(rd_log[2]), 32'd0);
            checkOutput($sformatf("f%0d rd c5", f), 32'(rd_log[5]), 32'd0);
            if (act_a_tab[f] != 0)
                checkOutput($sformatf("f%0d addr c1", f), 32'(addr_log[1]), 32'(adr_a_tab[f]));
            checkOutput($sformatf("f%0d active_a@c1", f), 32'(act_log1), 32'(act_a_tab[f]));
            checkOutput($sformatf("f%0d busy c1", f), 32'(busy_log[1]), 32'd1);
            checkOutput($sformatf("f%0d busy c6", f), 32'(busy_log[6]), 32'd1);
            checkOutput($sformatf("f%0d busy c7", f), 32'(busy_a), 32'd0);
            checkOutput($sformatf("f%0d out0_b", f), 32'(out0_b), 32'(out_b_tab[f]));
            checkOutput($sformatf("f%0d active_b0", f), 32'(active_b[0]), 32'(act_b_tab[f]));
        end

        // All four voices playing with a constant word that overflows high.
        mem_mode   = 1;
        const_data = 16'h6000;
        applyStimulus(16'd4000, 16'd4000, 16'd4000, 16'd4000);
        for (int c = 1; c <= 4; c++)
            checkOutput($sformatf("4v rd c%0d", c), 32'(rd_log[c]), 32'd1);
        checkOutput("4v rd c5", 32'(rd_log[5]), 32'd0);
        checkOutput("4v addr c1", 32'(addr_log[1]), 32'd1);
        checkOutput("4v addr c2", 32'(addr_log[2]), 32'd0);
        checkOutput("4v active", 32'(active_a), 32'hF);
        checkOutput("4v out1", 32'(out1_a), 32'h6000);
        checkOutput("4v mix sat hi", 32'(mix_a), 32'h7FFF);
        checkOutput("4v out1_b", 32'(out1_b), 32'h0100);
        checkOutput("4v out2_b", 32'(out2_b), 32'h0100);
        checkOutput("4v out3_b", 32'(out3_b), 32'h0100);
        checkOutput("4v mix_b", 32'(mix_b), 32'h0402);

        // Negative overflow, then an in-range sum.
        const_data = 16'hA000;
        applyStimulus(16'd4000, 16'd4000, 16'd4000, 16'd4000);
        checkOutput("4v out3 neg", 32'(out3_a), 32'hA000);
        checkOutput("4v mix sat lo", 32'(mix_a), 32'h8000);
        const_data = 16'h1000;
        applyStimulus(16'd4000, 16'd4000, 16'd4000, 16'd4000);
        checkOutput("4v mix in range", 32'(mix_a), 32'h4000);
        checkOutput("pre overrun", 32'(overrun_a), 32'd0);

        // Second strobe at cycle 3 is ignored but flagged.
        const_data = 16'h0800;
        strobe = 1'b1;
        @(negedge clk);
        strobe = 1'b0;
        @(negedge clk);
        @(negedge clk);
        strobe = 1'b1;
        @(negedge clk);
        strobe = 1'b0;
        checkOutput("ovr flag c4", 32'(overrun_a), 32'd1);
        checkOutput("ovr busy c4", 32'(busy_a), 32'd1);
        @(negedge clk);
        @(negedge clk);
        checkOutput("ovr mix c6 old", 32'(mix_a), 32'h4000);
        @(negedge clk);
        checkOutput("ovr busy c7", 32'(busy_a), 32'd0);
        checkOutput("ovr out1 c7", 32'(out1_a), 32'h0800);
        checkOutput("ovr mix c7", 32'(mix_a), 32'h2000);
        checkOutput("ovr sticky", 32'(overrun_a), 32'd1);
        checkOutput("ovr sticky b", 32'(overrun_b), 32'd1);
        @(negedge clk);
        checkOutput("ovr no extra frame", 32'(busy_a), 32'd0);

        // Asynchronous reset in cycle 3 of a frame.
        strobe = 1'b1;
        @(negedge clk);
        strobe = 1'b0;
        checkOutput("rst busy_b c1", 32'(busy_b), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("arst mem_rd", 32'(mem_rd_a), 32'd0);
        checkOutput("arst mem_addr", 32'(mem_addr_a), 32'd0);
        checkOutput("arst out0", 32'(out0_a), 32'd0);
        checkOutput("arst out2", 32'(out2_a), 32'd0);
        checkOutput("arst mix", 32'(mix_a), 32'd0);
        checkOutput("arst active", 32'(active_a), 32'd0);
        checkOutput("arst busy", 32'(busy_a), 32'd0);
        checkOutput("arst overrun", 32'(overrun_a), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Clean frame after reset with quiet inputs: nothing plays.
        applyStimulus(16'd0, 16'd0, 16'd0, 16'd0);
        checkOutput("post rst active c1", 32'(act_log1), 32'd0);
        checkOutput("post rst rd c1", 32'(rd_log[1]), 32'd0);
        checkOutput("post rst mix", 32'(mix_a), 32'd0);
        checkOutput("post rst busy c1", 32'(busy_log[1]), 32'd1);

        // Voice 2 alone: its read lands in cycle 3 only.
        applyStimulus(16'd0, 16'd0, 16'd4000, 16'd0);
        checkOutput("v2 rd c1", 32'(rd_log[1]), 32'd0);
        checkOutput("v2 rd c3", 32'(rd_log[3]), 32'd1);
        checkOutput("v2 rd c4", 32'(rd_log[4]), 32'd0);
        checkOutput("v2 addr c3", 32'(addr_log[3]), 32'd0);
        checkOutput("v2 active", 32'(active_a), 32'b0100);
        checkOutput("v2 out2", 32'(out2_a), 32'h0800);
        checkOutput("v2 out0", 32'(out0_a), 32'd0);
        checkOutput("v2 mix", 32'(mix_a), 32'h0800);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/sampler_voice_scheduler.md
# sampler_voice_scheduler

Four-voice playback scheduler that shares one single-port sample RAM read port between four trigger channels. Per audio frame, it detects triggers on the four input channels and advances each voice's playback position. It then reads the RAM once per active voice, time-multiplexed, and publishes the four voice outputs plus a saturated mix. It sits between the codec sample path (inputs/outputs) and the sample ROM/RAM, replacing per-channel RAM copies.

## Interface
Parameters:
- W, 16, sample width (signed audio and RAM data)
- ADDR_W, 12, RAM address width
- N_SAMPLES, 12'h690, sample length in words; legal range 1..2^ADDR_W
- FP_OFFSET, 2, fixed-point shift; millivolts to counts is mv <<< FP_OFFSET
- TRIG_HI_MV, 1000, trigger rising threshold (mV)
- TRIG_LO_MV, 500, trigger re-arm threshold (mV); must be < TRIG_HI_MV
- RATE_DIV, 2, frames per sample step; ≥1

Ports:
- clk  in  1  system clock; the only clock
- rst_n  in  1  asynchronous active-low reset
- strobe  in  1  one-clk pulse per audio frame, already synchronous to clk
- sample_in0..3  in  W  signed trigger inputs, stable while busy
- mem_addr  out  ADDR_W  RAM read address
- mem_rd  out  1  read enable; mem_data valid exactly 1 clk later
- mem_data  in  W  signed RAM read data
- sample_out0..3  out  W  signed per-voice output
- mix_out  out  W  signed saturated sum of the four voices
- active  out  4  per-voice playing flag
- busy  out  1  frame sequence in progress
- overrun  out  1  sticky: a strobe arrived while busy

## Operation
- Per-voice state: armed flag (Schmitt), active, pos[ADDR_W-1:0], div counter (range 0..RATE_DIV-1), and captured value.
- Trigger (evaluated at strobe, IDLE only):
  - If armed and sample_in >= TRIG_HI: fire, armed<=0.
  - If sample_in < TRIG_LO: armed<=1.
  - Levels between the thresholds leave armed unchanged.
- Fire: pos<=0, div<=0, active<=1. This also applies mid-playback, as a restart.
- Active voice without fire: if div==RATE_DIV-1 then div<=0 and pos advances; else div++.
- If pos==N_SAMPLES-1 and would advance: active<=0, pos<=0. The voice outputs 0 this frame.
- FSM states: IDLE, ISSUE (voice index v=0..3), DRAIN, MIX.
  - IDLE: on strobe, apply trigger/advance updates, then go to ISSUE v=0.
  - ISSUE v: mem_addr<=pos[v]. mem_rd<=active[v], using the post-update active flag. In the same cycle, capture mem_data for voice v-1 if its read was issued; inactive voices capture 0. v=3 goes to DRAIN.
  - DRAIN: capture voice 3, then go to MIX.
  - MIX: sum the four captures at W+2 bits and saturate to [-2^(W-1), 2^(W-1)-1]. Register sample_out0..3 and mix_out simultaneously. Go to IDLE.
- mem_rd is low in IDLE/DRAIN/MIX. mem_addr holds its last value when not reading.
- Strobe outside IDLE: ignored (no state change), overrun<=1. Only reset clears overrun.

## Timing
- Strobe in IDLE at cycle 0.
- ISSUE v0..v3 occupy cycles 1..4; mem_rd/mem_addr are registered outputs in those cycles.
- Captures occur at cycles 2..5. DRAIN is cycle 5. MIX is cycle 6.
- Outputs change visibly at cycle 7, i.e. strobe-to-output latency is 7 clk.
- busy is high during cycles 1..6 and low in IDLE.
- active updates visibly at cycle 1.
- Minimum strobe spacing is 7 clk; a strobe at cycle 7 is accepted.
- Reset (asynchronous, any state) returns all of the following to 0 immediately: mem_rd, mem_addr, sample_out0..3, mix_out, active, busy, overrun, pos, div. It also sets FSM=IDLE and armed=1.
- Reset mid-sequence discards partial captures; no output update occurs.

## Test plan
- Trigger then play: sample_in0 is 0 for 2 frames, then 4000 (1000 mV) held, with RAM[a]=a+1 and RATE_DIV=2. Required:
  - Voice 0 reads addr 0,0,1,1,2,… on successive frames.
  - sample_out0 = 1,1,2,2,3,… at 7 clk after each strobe.
  - mem_rd pulses only in cycle 1 of each frame.
- End of sample: N_SAMPLES=4, RATE_DIV=1. Required: sample_out0 = RAM[0..3], then 0. active[0] falls on the 5th frame. Holding the trigger high does not retrigger.
- Hysteresis and retrigger:
  - Input 4000 → 3000 (750 mV) → 4000: no retrigger.
  - Input 4000 → 1000 (250 mV) → 4000 mid-playback: pos restarts at 0.
- Four voices plus saturation: all voices triggered, RAM data 16'h6000. Required: four reads at cycles 1..4 in voice order, mix_out=16'h7FFF. With data 16'hA000: mix_out=16'h8000.
- Overrun: strobe at cycle 0 and again at cycle 3. Required: the second strobe is ignored, overrun=1 stays set, and the frame completes normally at cycle 7.
- Async reset: assert rst_n=0 at cycle 3 of a frame. Required: all outputs are 0 within the same cycle, FSM=IDLE, and the next strobe starts a clean frame with no voices active.
